// File: rtl/dmem_ctrl_pkg.sv
// Shared types, length encodings and FSM state type for the data-memory
// controller, plus small helpers for access length and I/O address decode.
package dmem_ctrl_pkg;

    localparam int ROB_BIT_DEF = 4;

    typedef logic [31:0]            WORD_TP;
    typedef logic [31:0]            ADDR_TP;
    typedef logic [ROB_BIT_DEF-1:0] ROB_IDX_TP;

    localparam WORD_TP    ZERO_WORD    = '0;
    localparam ROB_IDX_TP ZERO_ROB_IDX = '0;

    // Access length encoding is (bytes - 1); any other code behaves as a word.
    localparam logic [3:0] LEN_B = 4'd0;
    localparam logic [3:0] LEN_H = 4'd1;
    localparam logic [3:0] LEN_W = 4'd3;

    // Address bits [17:16] equal to this select the memory-mapped I/O region.
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2,
        S_COOL  = 2'd3
    } dmem_state_e;

    // Index of the last byte of an access (n - 1).
    function automatic logic [1:0] last_byte_idx(input logic [3:0] len);
        case (len)
            LEN_B:   return 2'd0;
            LEN_H:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic is_io_addr(input ADDR_TP addr);
        return addr[17:16] == IO_ADDR_HI;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Bus bundle between the data-memory controller, the load/store buffer,
// the ROB, the CDB load channel and the byte-wide RAM port.
interface dmem_ctrl_if import dmem_ctrl_pkg::*; #(
    parameter int ROB_BIT = ROB_BIT_DEF
) ();

    // Handshakes:
    //  - Load: ld_ena is a level the buffer holds (with stable ld_* fields)
    //    until it observes the one-cycle ld_done pulse; the request is taken
    //    on the edge the controller accepts it and may be abandoned on rb.
    //  - Store: st_ena is a one-cycle pulse, taken only while st_ready=1;
    //    st_ready drops on the accepting edge and returns with st_done.
    //  - RAM: mem_din carries the byte addressed by the current mem_a;
    //    a byte is written on each edge that sees mem_wr=1.
    logic               ld_ena;
    ADDR_TP             ld_addr;
    logic [3:0]         ld_len;
    logic               ld_sext;
    logic [ROB_BIT-1:0] ld_src;
    logic               ld_done;
    WORD_TP             ld_data;

    logic               cdb_ld_valid;
    logic [ROB_BIT-1:0] cdb_ld_src;
    WORD_TP             cdb_ld_val;

    logic               st_ena;
    ADDR_TP             st_addr;
    logic [3:0]         st_len;
    WORD_TP             st_data;
    logic               st_ready;
    logic               st_done;

    ADDR_TP             mem_a;
    logic [7:0]         mem_dout;
    logic               mem_wr;
    logic [7:0]         mem_din;

    modport master (
        output ld_ena, ld_addr, ld_len, ld_sext, ld_src,
        output st_ena, st_addr, st_len, st_data,
        output mem_din,
        input  ld_done, ld_data, cdb_ld_valid, cdb_ld_src, cdb_ld_val,
        input  st_ready, st_done,
        input  mem_a, mem_dout, mem_wr
    );

    modport slave (
        input  ld_ena, ld_addr, ld_len, ld_sext, ld_src,
        input  st_ena, st_addr, st_len, st_data,
        input  mem_din,
        output ld_done, ld_data, cdb_ld_valid, cdb_ld_src, cdb_ld_val,
        output st_ready, st_done,
        output mem_a, mem_dout, mem_wr
    );

endinterface

// File: rtl/dmem_ctrl_ld_ext.sv
// Load result extension: narrows the assembled little-endian word to the
// access length and sign- or zero-extends it back to 32 bits.
module dmem_ctrl_ld_ext import dmem_ctrl_pkg::*; (
    input  WORD_TP     raw_i,
    input  logic [3:0] len_i,
    input  logic       sext_i,
    output WORD_TP     ext_o
);

    // Byte/half replicate their top bit only when sign extension is asked for.
    always_comb begin
        ext_o = raw_i;
        case (len_i)
            LEN_B:   ext_o = {{24{sext_i & raw_i[7]}},  raw_i[7:0]};
            LEN_H:   ext_o = {{16{sext_i & raw_i[15]}}, raw_i[15:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: sequences one speculative load and one committed
// store at a time over a byte-wide RAM port and returns load results to the
// buffer and the CDB. A one-entry store buffer decouples the ROB commit pulse
// from RAM availability; a buffered store always wins over a new load.
// Optional feature macro: DMEM_IO_GUARD_EN holds stores to the I/O region
// while the UART FIFO is full and lets non-I/O loads overtake them.
module dmem_ctrl import dmem_ctrl_pkg::*; #(
    parameter int ROB_BIT = ROB_BIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_i,
    input  logic        rb_i,
    input  logic        io_buffer_full_i,
    dmem_ctrl_if.slave  bus,
    output dmem_state_e dbg_state_o
);

    dmem_state_e        state_q,    state_d;
    logic [1:0]         k_q,        k_d;

    // Latched load request and partially assembled bytes.
    ADDR_TP             ld_addr_q,  ld_addr_d;
    logic [3:0]         ld_len_q,   ld_len_d;
    logic               ld_sext_q,  ld_sext_d;
    logic [ROB_BIT-1:0] ld_src_q,   ld_src_d;
    WORD_TP             ld_buf_q,   ld_buf_d;

    // One-entry committed-store buffer.
    logic               st_full_q,  st_full_d;
    ADDR_TP             st_addr_q,  st_addr_d;
    logic [3:0]         st_len_q,   st_len_d;
    WORD_TP             st_data_q,  st_data_d;

    // Registered outputs; the load result register feeds both the buffer and the CDB.
    logic               done_q,     done_d;
    WORD_TP             res_q,      res_d;
    logic [ROB_BIT-1:0] res_src_q,  res_src_d;
    logic               st_done_q,  st_done_d;
    ADDR_TP             mem_a_q,    mem_a_d;
    logic [7:0]         mem_dout_q, mem_dout_d;
    logic               mem_wr_q,   mem_wr_d;

    WORD_TP             raw_word;
    WORD_TP             ext_word;
    logic [1:0]         k_inc;
    logic               store_go;
    logic               load_go;

`ifdef DMEM_IO_GUARD_EN
    // An I/O store waits for FIFO space; only non-I/O loads may overtake it.
    assign store_go = !(is_io_addr(st_addr_q) && io_buffer_full_i);
    assign load_go  = !st_full_q || !is_io_addr(bus.ld_addr);
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full_i;
    assign store_go       = 1'b1;
    assign load_go        = !st_full_q;
`endif

    // Merge the byte arriving this cycle into the partially assembled word.
    always_comb begin
        raw_word = ld_buf_q;
        raw_word[{k_q, 3'b000} +: 8] = bus.mem_din;
    end

    dmem_ctrl_ld_ext u_ld_ext (
        .raw_i  (raw_word),
        .len_i  (ld_len_q),
        .sext_i (ld_sext_q),
        .ext_o  (ext_word)
    );

    // Next-state and next-output logic for the store buffer and the FSM.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        ld_addr_d  = ld_addr_q;
        ld_len_d   = ld_len_q;
        ld_sext_d  = ld_sext_q;
        ld_src_d   = ld_src_q;
        ld_buf_d   = ld_buf_q;
        st_full_d  = st_full_q;
        st_addr_d  = st_addr_q;
        st_len_d   = st_len_q;
        st_data_d  = st_data_q;
        done_d     = 1'b0;
        res_d      = res_q;
        res_src_d  = res_src_q;
        st_done_d  = 1'b0;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        k_inc      = k_q + 2'd1;

        // A pulse while the buffer is occupied is a protocol error and is dropped.
        if (bus.st_ena && !st_full_q) begin
            st_full_d = 1'b1;
            st_addr_d = bus.st_addr;
            st_len_d  = bus.st_len;
            st_data_d = bus.st_data;
        end

        case (state_q)
            S_IDLE: begin
                if (st_full_q && store_go) begin
                    state_d    = S_STORE;
                    k_d        = 2'd0;
                    mem_wr_d   = 1'b1;
                    mem_a_d    = st_addr_q;
                    mem_dout_d = st_data_q[7:0];
                end else if (bus.ld_ena && !rb_i && load_go) begin
                    // A request seen together with rb belongs to the flushed path.
                    state_d   = S_LOAD;
                    k_d       = 2'd0;
                    ld_addr_d = bus.ld_addr;
                    ld_len_d  = bus.ld_len;
                    ld_sext_d = bus.ld_sext;
                    ld_src_d  = bus.ld_src;
                    ld_buf_d  = ZERO_WORD;
                    mem_a_d   = bus.ld_addr;
                end
            end

            S_LOAD: begin
                if (rb_i) begin
                    // Partial bytes are simply abandoned; ld_buf is cleared on the next accept.
                    state_d = S_IDLE;
                end else begin
                    ld_buf_d = raw_word;
                    k_d      = k_inc;
                    mem_a_d  = ld_addr_q + 32'(k_q) + 32'd1;
                    if (k_q == last_byte_idx(ld_len_q)) begin
                        state_d   = S_COOL;
                        done_d    = 1'b1;
                        res_d     = ext_word;
                        res_src_d = ld_src_q;
                    end
                end
            end

            S_STORE: begin
                if (k_q == last_byte_idx(st_len_q)) begin
                    state_d   = S_IDLE;
                    mem_wr_d  = 1'b0;
                    st_done_d = 1'b1;
                    st_full_d = 1'b0;
                end else begin
                    k_d        = k_inc;
                    mem_a_d    = st_addr_q + 32'(k_q) + 32'd1;
                    mem_dout_d = st_data_q[{k_inc, 3'b000} +: 8];
                end
            end

            // The buffer is still holding ld_ena for the request just finished.
            S_COOL: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; rdy low freezes every register including the store buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= 2'd0;
            ld_addr_q  <= ZERO_WORD;
            ld_len_q   <= LEN_B;
            ld_sext_q  <= 1'b0;
            ld_src_q   <= '0;
            ld_buf_q   <= ZERO_WORD;
            st_full_q  <= 1'b0;
            st_addr_q  <= ZERO_WORD;
            st_len_q   <= LEN_B;
            st_data_q  <= ZERO_WORD;
            done_q     <= 1'b0;
            res_q      <= ZERO_WORD;
            res_src_q  <= '0;
            st_done_q  <= 1'b0;
            mem_a_q    <= ZERO_WORD;
            mem_dout_q <= 8'h00;
            mem_wr_q   <= 1'b0;
        end else if (rdy_i) begin
            state_q    <= state_d;
            k_q        <= k_d;
            ld_addr_q  <= ld_addr_d;
            ld_len_q   <= ld_len_d;
            ld_sext_q  <= ld_sext_d;
            ld_src_q   <= ld_src_d;
            ld_buf_q   <= ld_buf_d;
            st_full_q  <= st_full_d;
            st_addr_q  <= st_addr_d;
            st_len_q   <= st_len_d;
            st_data_q  <= st_data_d;
            done_q     <= done_d;
            res_q      <= res_d;
            res_src_q  <= res_src_d;
            st_done_q  <= st_done_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign bus.ld_done      = done_q;
    assign bus.ld_data      = res_q;
    assign bus.cdb_ld_valid = done_q;
    assign bus.cdb_ld_src   = res_src_q;
    assign bus.cdb_ld_val   = res_q;
    assign bus.st_ready     = ~st_full_q;
    assign bus.st_done      = st_done_q;
    assign bus.mem_a        = mem_a_q;
    assign bus.mem_dout     = mem_dout_q;
    // The RAM freezes with the core, so no write may leak out while rdy is low.
    assign bus.mem_wr       = mem_wr_q & rdy_i;
    assign dbg_state_o      = state_q;

endmodule
